// File: rtl/instr_pkg.sv
// Shared types and default widths for the multi-thread instruction buffer.
// Holds the entry layout plus the round-robin index helper used by the arbiter.
package instr_pkg;

   localparam int XLEN         = 32;
   localparam int INSTR_WIDTH  = 32;
   localparam int NUM_THREADS  = 4;
   localparam int THREAD_WIDTH = $clog2(NUM_THREADS);
   localparam int DEPTH        = 4;

   typedef struct packed {
      logic [THREAD_WIDTH-1:0] thread_id;
      logic [XLEN-1:0]         pc;
      logic [INSTR_WIDTH-1:0]  instr;
   } instr_entry_t;

   // idx is at most 2*n-1, so a single conditional subtract wraps it
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/instr_thread_fifo.sv
// Single-thread synchronous FIFO; combinational head read, push/pop take effect at the edge.
// Push while full and pop while empty are ignored; flush clears pointers and count at once.
module instr_thread_fifo #(
   parameter int W     = $bits(instr_pkg::instr_entry_t),
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_mt_buf.sv
// Multi-thread fetch->decode buffer: per-thread FIFOs, round-robin issue into a registered output.
// Empty-buffer latency 2 edges; per-thread in_ready from registered counts, output held while stalled or unacked.
module instr_mt_buf #(
   parameter int XLEN         = instr_pkg::XLEN,
   parameter int INSTR_WIDTH  = instr_pkg::INSTR_WIDTH,
   parameter int NUM_THREADS  = instr_pkg::NUM_THREADS,
   parameter int THREAD_WIDTH = $clog2(NUM_THREADS),
   parameter int DEPTH        = instr_pkg::DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall_i,
   input  logic                    in_valid_i,
   input  logic [THREAD_WIDTH-1:0] in_thread_id_i,
   input  logic [XLEN-1:0]         in_pc_i,
   input  logic [INSTR_WIDTH-1:0]  in_instr_i,
   output logic [NUM_THREADS-1:0]  in_ready_o,
   input  logic [NUM_THREADS-1:0]  flush_i,
   input  logic                    decode_ack_i,
   output logic                    out_valid_o,
   output logic [THREAD_WIDTH-1:0] out_thread_id_o,
   output logic [XLEN-1:0]         out_pc_o,
   output logic [INSTR_WIDTH-1:0]  out_instr_o,
   output logic                    fifo_empty_o,
   output logic                    overflow_o
);
   import instr_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [THREAD_WIDTH-1:0] thread_id;
      logic [XLEN-1:0]         pc;
      logic [INSTR_WIDTH-1:0]  instr;
   } entry_t;

   localparam int EW = $bits(entry_t);

   logic [NUM_THREADS-1:0]  push;
   logic [NUM_THREADS-1:0]  pop;
   logic [NUM_THREADS-1:0]  full;
   logic [NUM_THREADS-1:0]  empty;
   logic [NUM_THREADS-1:0]  elig;
   logic [NUM_THREADS-1:0]  nonempty_nxt;
   logic [CW-1:0]           cnt      [NUM_THREADS];
   logic [EW-1:0]           head_raw [NUM_THREADS];
   entry_t                  head     [NUM_THREADS];
   entry_t                  in_entry;
   entry_t                  out_q;
   logic                    out_vld_q;
   logic                    out_vld_nxt;
   logic                    ovf_q;
   logic                    empty_q;
   logic                    load;
   logic                    grant_vld;
   logic [THREAD_WIDTH-1:0] grant;
   logic [THREAD_WIDTH-1:0] cand;
   logic [THREAD_WIDTH-1:0] rr_q;

   assign in_entry = '{thread_id: in_thread_id_i, pc: in_pc_i, instr: in_instr_i};
   assign load     = !stall_i && (!out_vld_q || decode_ack_i);

   genvar t;
   generate
      for (t = 0; t < NUM_THREADS; t++) begin : g_thr
         // a flushed thread neither accepts the same-cycle write nor competes for the grant
         assign push[t] = in_valid_i && (int'(in_thread_id_i) == t) && !full[t] && !flush_i[t];
         assign pop[t]  = load && grant_vld && (int'(grant) == t);
         assign elig[t] = !empty[t] && !flush_i[t];
         assign head[t] = entry_t'(head_raw[t]);
         assign nonempty_nxt[t] = !flush_i[t] &&
                                  ((cnt[t] + CW'(push[t]) - CW'(pop[t])) != '0);

         instr_thread_fifo #(
            .W     (EW),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[t]),
            .pop   (pop[t]),
            .flush (flush_i[t]),
            .din   (in_entry),
            .dout  (head_raw[t]),
            .count (cnt[t]),
            .full  (full[t]),
            .empty (empty[t])
         );
      end
   endgenerate

   always_comb begin
      grant_vld = 1'b0;
      grant     = rr_q;
      cand      = rr_q;
      for (int i = 1; i <= NUM_THREADS; i++) begin
         cand = THREAD_WIDTH'(rr_wrap(int'(rr_q) + i, NUM_THREADS));
         if (!grant_vld && elig[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   always_comb begin
      out_vld_nxt = out_vld_q;
      if (load) begin
         out_vld_nxt = grant_vld;
      end else if (out_vld_q && flush_i[out_q.thread_id]) begin
         out_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
         rr_q      <= THREAD_WIDTH'(NUM_THREADS - 1);
         ovf_q     <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         out_vld_q <= out_vld_nxt;
         if (load && grant_vld) begin
            out_q <= head[grant];
            rr_q  <= grant;
         end
         if (in_valid_i && full[in_thread_id_i] && !flush_i[in_thread_id_i]) ovf_q <= 1'b1;
         empty_q <= !(|nonempty_nxt) && !out_vld_nxt;
      end
   end

   assign in_ready_o      = ~full;
   assign out_valid_o     = out_vld_q;
   assign out_thread_id_o = out_q.thread_id;
   assign out_pc_o        = out_q.pc;
   assign out_instr_o     = out_q.instr;
   assign fifo_empty_o    = empty_q;
   assign overflow_o      = ovf_q;

endmodule

// File: doc/instr_mt_buf.md
Name: instr_mt_buf

Overview:
- Parametrised multi-thread instruction buffer between fetch and decode.
- Per-thread FIFO of {thread_id, pc, instr} entries, written by the fetch stage.
- Issues one entry per cycle to decode through a registered output stage, selected round-robin across non-empty threads.
- Adds per-thread backpressure, per-thread flush and overflow reporting.

Parameters:
- XLEN, 32, pc width
- INSTR_WIDTH, 32, instruction width
- NUM_THREADS, 4, hardware threads; must be ≥2
- THREAD_WIDTH, $clog2(NUM_THREADS), thread id width
- DEPTH, 4, entries per thread FIFO; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  freeze issue: output register held, no pop
- in_valid_i  in  1  fetch entry valid this cycle
- in_thread_id_i  in  THREAD_WIDTH  thread of entry
- in_pc_i  in  XLEN  pc of entry
- in_instr_i  in  INSTR_WIDTH  instruction word
- in_ready_o  out  NUM_THREADS  bit t=1: thread t FIFO not full
- flush_i  in  NUM_THREADS  bit t=1: discard all thread t entries
- decode_ack_i  in  1  decode consumed current output
- out_valid_o  out  1  output entry valid
- out_thread_id_o  out  THREAD_WIDTH  output thread id
- out_pc_o  out  XLEN  output pc
- out_instr_o  out  INSTR_WIDTH  output instruction
- fifo_empty_o  out  1  all FIFOs empty and output invalid
- overflow_o  out  1  sticky: write attempted to a full thread

Behaviour:
- Reset (rst high at posedge):
  - All FIFO pointers and counts cleared; RR pointer = NUM_THREADS-1, so thread 0 has first priority.
  - out_valid_o=0, out_thread_id_o/out_pc_o/out_instr_o=0, in_ready_o=all 1, fifo_empty_o=1, overflow_o=0.
  - Reset mid-operation discards all entries with no partial state.
- Write:
  - in_valid_i && in_ready_o[tid] → entry pushed at the edge.
  - in_valid_i while full → entry dropped, overflow_o set (cleared only by rst).
  - in_ready_o derives from registered count; a pop in the same cycle does not make a full FIFO ready.
- Output register load: when !stall_i && (!out_valid_o || decode_ack_i):
  - Arbiter grants the first non-empty thread after the RR pointer, wrapping at NUM_THREADS-1 → 0.
  - The granted head is popped and loaded into the output register; RR pointer = granted thread.
  - If no thread is non-empty, out_valid_o clears on ack.
  - Arbiter eligibility uses registered counts, so an entry written at edge k is loadable at edge k+1 and visible on outputs after edge k+1.
  - Empty-buffer latency is therefore 2 edges, in_valid_i to out_valid_o.
- decode_ack_i while !out_valid_o: ignored.
- Stall:
  - stall_i=1 → output register and RR pointer hold, decode_ack_i ignored.
  - Writes and flushes still act.
- Throughput: 1 entry/cycle with decode_ack_i held high and ≥1 thread non-empty.
- Flush flush_i[t]:
  - Thread t count and pointers cleared at the edge.
  - Output register invalidated if it holds thread t.
  - A same-cycle write to t is dropped; this is not an overflow.
  - A same-cycle arbiter grant to t is suppressed; the arbiter picks the next eligible thread instead.
  - Flush takes priority over ack.
  - Multiple bits may be set at once.
- Ordering: entries of one thread issue in write order; no ordering guarantee across threads.
- Pointers are log2(DEPTH) bits wrapping naturally; count is log2(DEPTH)+1 bits; full when count==DEPTH.
- fifo_empty_o is registered and consistent with the state after each edge.

Decomposition:
- Shared package instr_pkg: typedef instr_entry_t {thread_id, pc, instr} (parametrised widths), XLEN/INSTR_WIDTH/THREAD_WIDTH constants.
- Sub-module instr_thread_fifo: single-thread sync FIFO.
  - Ports: push, pop, flush, entry in/out, count, full, empty.
  - Instantiated NUM_THREADS times in a generate loop.
- RR arbiter stays inline.

Test Plan:
- Reset: drive rst 2 cycles with in_valid_i=1 → out_valid_o=0, in_ready_o=4'b1111, fifo_empty_o=1, overflow_o=0.
- Latency and order: write thread 1 pc=16, then pc=20 on consecutive cycles, decode_ack_i=1 → out {1,16} visible after 2nd edge, {1,20} the next cycle, then out_valid_o=0, fifo_empty_o=1.
- Round-robin:
  - Stimulus: preload threads 0, 2, 3 with two entries each, then ack continuously.
  - Required issue order: 0, 2, 3, 0, 2, 3.
  - Thread 1 is skipped.
- Full and overflow:
  - Stimulus: write 5 entries to thread 2 with no ack; the output register has already taken the first entry.
  - Required: in_ready_o[2]=0 after 5 accepted entries.
  - Stimulus: a 6th write.
  - Required: overflow_o=1, entry absent from the later issue stream.
- Stall: out_valid_o=1 showing pc=0x40, stall_i=1 for 3 cycles with decode_ack_i=1 → outputs unchanged; writes to thread 3 still accepted.
- Flush:
  - Stimulus: thread 0 holds 3 entries and the output shows thread 0 pc=0x100; assert flush_i[0] together with a write to thread 0.
  - Required next cycle: out_valid_o=0 or a different thread shown, thread 0 count=0, overflow_o unchanged.
